// File: rtl/enemy_march_ctrl.sv
// enemy_march_ctrl
//   Formation-level march controller. It looks at the live extent of every
//   enemy column and produces the shared step commands that all columns apply.
//   The march period shortens as columns die. The block also flags game-over
//   (any column has landed) and wave-cleared (every column is dead).
// Ports
//   clk_i, reset_ni        : clock and synchronous active-low reset
//   frame_i                : one-cycle pulse per video frame
//   column_left_i/right_i  : packed 10-bit extents, column k at [10k+9:10k]
//   column_dead_i          : per-column all-dead flags
//   column_landed_i        : per-column landed flags
//   step_right/left/down_o : one-cycle step commands (mutually exclusive)
//   dir_right_o            : current march direction (1 = right)
//   step_px_o              : horizontal step size in pixels
//   period_o               : frames per step currently in force
//   game_over_o, cleared_o : sticky terminal indications
module enemy_march_ctrl #(
  parameter int unsigned num_columns_p  = 11,
  parameter logic [9:0]  screen_left_p  = 10'd8,
  parameter logic [9:0]  screen_right_p = 10'd631,
  parameter logic [9:0]  step_px_p      = 10'd2,
  parameter logic [5:0]  base_period_p  = 6'd32,
  parameter logic [5:0]  speedup_p      = 6'd2,
  parameter logic [5:0]  min_period_p   = 6'd4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       frame_i,
  input  logic [10*num_columns_p-1:0] column_left_i,
  input  logic [10*num_columns_p-1:0] column_right_i,
  input  logic [num_columns_p-1:0]   column_dead_i,
  input  logic [num_columns_p-1:0]   column_landed_i,
  output logic                       step_right_o,
  output logic                       step_left_o,
  output logic                       step_down_o,
  output logic                       dir_right_o,
  output logic [9:0]                 step_px_o,
  output logic [5:0]                 period_o,
  output logic                       game_over_o,
  output logic                       cleared_o
);

  typedef enum logic [1:0] {MARCH_R = 2'd0, MARCH_L = 2'd1, HALT = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] period_q, period_d;
  logic       right_q, right_d, left_q, left_d, down_q, down_d;
  logic       dir_q, dir_d, go_q, go_d, clr_q, clr_d;

  logic [9:0]  min_left, max_right;
  logic [7:0]  dead_count;
  logic [13:0] dec;
  logic [5:0]  target;
  logic        tick, right_hit, left_hit, landed_any, all_dead;

  // Extent over live columns only; dead columns may hold stale positions.
  always_comb begin
    min_left   = 10'h3FF;
    max_right  = '0;
    dead_count = '0;
    for (int k = 0; k < int'(num_columns_p); k++) begin
      if (!column_dead_i[k]) begin
        if (column_left_i[10*k +: 10] < min_left)   min_left  = column_left_i[10*k +: 10];
        if (column_right_i[10*k +: 10] > max_right) max_right = column_right_i[10*k +: 10];
      end
      dead_count = dead_count + 8'(column_dead_i[k]);
    end
  end

  // Saturating period: anything at or below the floor (including a negative
  // difference) clamps to min_period_p.
  always_comb begin
    dec = 14'(speedup_p) * 14'(dead_count);
    if (dec >= 14'(base_period_p) ||
        (14'(base_period_p) - dec) < 14'(min_period_p))
      target = min_period_p;
    else
      target = base_period_p - 6'(dec);
  end

  assign landed_any = |column_landed_i;
  assign all_dead   = &column_dead_i;
  assign tick       = frame_i && (count_q == period_q - 6'd1);
  // 11-bit compares so edge + step cannot wrap.
  assign right_hit  = ({1'b0, max_right} + {1'b0, step_px_p}) > {1'b0, screen_right_p};
  assign left_hit   = {1'b0, min_left} < ({1'b0, screen_left_p} + {1'b0, step_px_p});

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= MARCH_R;
    else           state_q <= state_d;
  end

  // Next-state logic; a halt condition overrides a coincident tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MARCH_R: if (landed_any || all_dead) state_d = HALT;
               else if (tick && right_hit) state_d = MARCH_L;
      MARCH_L: if (landed_any || all_dead) state_d = HALT;
               else if (tick && left_hit)  state_d = MARCH_R;
      HALT:    state_d = HALT;
      default: state_d = MARCH_R;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    right_d  = 1'b0;
    left_d   = 1'b0;
    down_d   = 1'b0;
    go_d     = go_q;
    clr_d    = clr_q;
    count_d  = count_q;
    period_d = period_q;
    if (state_q == MARCH_R || state_q == MARCH_L) begin
      if (landed_any)    go_d  = 1'b1;
      else if (all_dead) clr_d = 1'b1;
      else if (frame_i) begin
        if (tick) begin
          count_d  = '0;
          period_d = target;
          if (state_q == MARCH_R) begin
            down_d  = right_hit;
            right_d = !right_hit;
          end else begin
            down_d  = left_hit;
            left_d  = !left_hit;
          end
        end else begin
          count_d = count_q + 6'd1;
        end
      end
    end
    // Direction follows the state; HALT keeps the last one.
    case (state_d)
      MARCH_R: dir_d = 1'b1;
      MARCH_L: dir_d = 1'b0;
      default: dir_d = dir_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count_q  <= '0;
      period_q <= base_period_p;
      right_q  <= 1'b0;
      left_q   <= 1'b0;
      down_q   <= 1'b0;
      dir_q    <= 1'b1;
      go_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      right_q  <= right_d;
      left_q   <= left_d;
      down_q   <= down_d;
      dir_q    <= dir_d;
      go_q     <= go_d;
      clr_q    <= clr_d;
    end
  end

  assign step_right_o = right_q;
  assign step_left_o  = left_q;
  assign step_down_o  = down_q;
  assign dir_right_o  = dir_q;
  assign step_px_o    = step_px_p;
  assign period_o     = period_q;
  assign game_over_o  = go_q;
  assign cleared_o    = clr_q;

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Directed bench for enemy_march_ctrl: a frame-level model of the march rules
// is compared against the DUT every cycle, and literal expectations pin the
// model at key points of each scenario.
module tb_enemy_march_ctrl;
  localparam int NC   = 11;
  localparam int SL   = 8;
  localparam int SR   = 631;
  localparam int PX   = 2;
  localparam int BASE = 32;
  localparam int SPD  = 2;
  localparam int MINP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame = 1'b0;
  logic [10*NC-1:0] col_left = '0, col_right = '0;
  logic [NC-1:0] dead = '0, landed = '0;
  logic s_right, s_left, s_down, dir_r, go, clr;
  logic [9:0] spx;
  logic [5:0] per;

  enemy_march_ctrl dut (
    .clk_i(clk), .reset_ni(rst_n), .frame_i(frame),
    .column_left_i(col_left), .column_right_i(col_right),
    .column_dead_i(dead), .column_landed_i(landed),
    .step_right_o(s_right), .step_left_o(s_left), .step_down_o(s_down),
    .dir_right_o(dir_r), .step_px_o(spx), .period_o(per),
    .game_over_o(go), .cleared_o(clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_right = 0, n_left = 0, n_down = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: frame counting, direction, period and halt rules.
  int  m_cnt, m_per, mn, mx, nd, tgt;
  bit  m_dir, m_halt, m_go, m_clr, e_r, e_l, e_d;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_per = BASE; m_dir = 1; m_halt = 0; m_go = 0; m_clr = 0;
      e_r = 0; e_l = 0; e_d = 0;
    end else begin
      e_r = 0; e_l = 0; e_d = 0;
      if (!m_halt) begin
        mn = 1023; mx = 0; nd = 0;
        for (int k = 0; k < NC; k++) begin
          if (dead[k]) nd++;
          else begin
            if (int'(col_left[k*10 +: 10]) < mn)  mn = int'(col_left[k*10 +: 10]);
            if (int'(col_right[k*10 +: 10]) > mx) mx = int'(col_right[k*10 +: 10]);
          end
        end
        if (landed != 0) begin m_go = 1; m_halt = 1; end
        else if (nd == NC) begin m_clr = 1; m_halt = 1; end
        else if (frame) begin
          if (m_cnt + 1 == m_per) begin
            m_cnt = 0;
            tgt = BASE - SPD * nd;
            m_per = (tgt < MINP) ? MINP : tgt;
            if (m_dir) begin
              if (mx + PX > SR) begin e_d = 1; m_dir = 0; end else e_r = 1;
            end else begin
              if (mn < SL + PX) begin e_d = 1; m_dir = 1; end else e_l = 1;
            end
          end else m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("step_right", s_right, e_r);
      chk("step_left",  s_left,  e_l);
      chk("step_down",  s_down,  e_d);
      chk("dir_right",  dir_r,   m_dir);
      chk("period",     per,     m_per);
      chk("game_over",  go,      m_go);
      chk("cleared",    clr,     m_clr);
      chk("step_px",    spx,     PX);
      if (s_right) n_right++;
      if (s_left)  n_left++;
      if (s_down)  n_down++;
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame = 1'b1;
      @(negedge clk); frame = 1'b0;
    end
    #1;
  endtask

  task automatic set_all(input int l, input int r);
    for (int k = 0; k < NC; k++) begin
      col_left[k*10 +: 10]  = 10'(l + k);
      col_right[k*10 +: 10] = 10'(r - k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  int r0, l0, d0;

  initial begin
    set_all(100, 300);
    do_reset();
    chk_en = 1;
    chk("rst_period", per, 32);
    chk("rst_dir", dir_r, 1);
    chk("rst_flags", {go, clr, s_right, s_left, s_down}, 0);

    // 64 frames, two right steps, period unchanged
    frames(64);
    chk("right_count_64", n_right, 2);
    chk("period_64", per, 32);

    // right wall: drop and reverse, then step left
    col_right[10*10 +: 10] = 10'd630;
    frames(32);
    chk("down_at_wall", n_down, 1);
    chk("dir_after_down", dir_r, 0);
    set_all(200, 300);
    frames(32);
    chk("left_count", n_left, 1);

    // dead column 0 with stale left=0 must not cause a drop
    set_all(50, 150);
    col_left[9:0] = 10'd0;
    dead[0] = 1'b1;
    frames(32);
    chk("left_dead_ignored", n_left, 2);
    chk("down_unchanged", n_down, 1);
    chk("period_1dead", per, 30);

    // period shortening applied only at tick
    dead = '0;
    do_reset();
    set_all(100, 300);
    dead = 11'h3FF;
    frames(16);
    chk("period_midinterval", per, 32);
    r0 = n_right;
    frames(16);
    chk("period_10dead", per, 12);
    frames(12);
    chk("right_after_12", n_right - r0, 2);
    dead = 11'h007;
    frames(6);
    chk("period_still_12", per, 12);
    frames(6);
    chk("period_3dead", per, 26);

    // landing on the tick cycle: halt wins
    dead = '0;
    do_reset();
    frames(31);
    r0 = n_right; l0 = n_left; d0 = n_down;
    @(negedge clk); frame = 1'b1; landed[3] = 1'b1;
    @(negedge clk); frame = 1'b0; #1;
    chk("landed_go", go, 1);
    chk("landed_nopulse", n_right - r0, 0);
    frames(40);
    chk("halt_nopulse", (n_right - r0) + (n_left - l0) + (n_down - d0), 0);
    chk("halt_go_sticky", go, 1);

    // landed and cleared together, then reset resumes marching
    landed = '0;
    do_reset();
    @(negedge clk); dead = '1; landed[5] = 1'b1;
    @(negedge clk); #1;
    chk("both_go", go, 1);
    chk("both_clr", clr, 0);
    @(negedge clk); rst_n = 1'b0; dead = '0; landed = '0;
    @(negedge clk); #1;
    chk("rst2_go", go, 0);
    chk("rst2_period", per, 32);
    chk("rst2_dir", dir_r, 1);
    rst_n = 1'b1;
    r0 = n_right;
    frames(32);
    chk("resume_right", n_right - r0, 1);

    // all dead alone: cleared
    @(negedge clk); dead = '1;
    @(negedge clk); #1;
    chk("cleared_only", clr, 1);
    chk("cleared_nogo", go, 0);
    frames(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
